ppt_regmap_mc: RTL

Multi-channel, parametrised register map between the I2C slave register port and N PPT pulse controllers. Each channel has its own configuration bank and status bank. Configuration writes land in shadow registers and reach the controllers only on an explicit atomic commit. Each channel also gets a sticky DONE flag (write-1-to-clear), optional auto-stop of RUN, and a global interrupt output.

---
 rtl/ppt_regmap_mc.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ppt_regmap_mc.sv
// ppt_regmap_mc
// Register map between the I2C slave register port and NUM_CH PPT pulse
// controllers. Each channel has a shadow configuration bank (CLK_DIV, PERIOD,
// WIDTH, COUNT). The shadow bank is copied to the active outputs only by an
// atomic COMMIT write on the global page. Each channel also has an unshadowed
// CTRL register, sampled count/done status, and a sticky write-1-to-clear DONE
// flag that feeds a registered global interrupt.
//
// Ports
//   clk, rstn        system clock, asynchronous active-low reset
//   address          [7:4] page (channel index, or 0xF for global), [3:0] offset
//   data_in          write data
//   write_enable     single-cycle write strobe
//   data_out         combinational read data for the current address
//   run_on_reset     reset value of every channel's RUN bit
//   clk_div/period/width/count  active configuration, channel i in slice i
//   run_ppt          RUN bit per channel
//   count_done       firings completed per channel (sampled every cycle)
//   done             controller done level per channel (sampled every cycle)
//   irq              OR over channels of DONE_STICKY & IRQ_EN, registered
module ppt_regmap_mc #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 5,
    parameter int PER_W  = 14,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [7:0]                address,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    input  logic                      write_enable,
    input  logic                      run_on_reset,
    output logic [NUM_CH*DIV_W-1:0]   clk_div,
    output logic [NUM_CH*PER_W-1:0]   period,
    output logic [NUM_CH*PER_W-1:0]   width,
    output logic [NUM_CH*CNT_W-1:0]   count,
    output logic [NUM_CH-1:0]         run_ppt,
    input  logic [NUM_CH*CNT_W-1:0]   count_done,
    input  logic [NUM_CH-1:0]         done,
    output logic                      irq
);

    logic [3:0]        page;
    logic [3:0]        off;
    logic              commit_wr;
    logic [NUM_CH-1:0] irq_next_vec;
    logic [NUM_CH-1:0] irq_stat;
    logic [7:0]        rd_ch [NUM_CH];

    assign page      = address[7:4];
    assign off       = address[3:0];
    assign commit_wr = write_enable && (page == 4'hF) && (off == 4'h1);

    // Replace one byte of a zero-extended field; bits above the real field
    // width are dropped by the caller's cast, so H writes to narrow fields vanish.
    function automatic logic [15:0] merge_byte(input logic [15:0] cur,
                                               input logic        hi,
                                               input logic [7:0]  d);
        return hi ? {d, cur[7:0]} : {cur[15:8], d};
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] sh_div, act_div;
        logic [PER_W-1:0] sh_per, act_per, sh_wid, act_wid;
        logic [CNT_W-1:0] sh_cnt, act_cnt, cnt_done_q;
        logic             run_q, auto_stop_q, irq_en_q, sticky_q, done_q;
        logic             wr, ctrl_wr, clr, rise, do_commit;
        logic             sticky_next, irq_en_next;
        logic [15:0]      per16, wid16, cnt16, cd16;
        logic [7:0]       rd;

        assign wr          = write_enable && (page == 4'(i));
        assign ctrl_wr     = wr && (off == 4'h7);
        assign clr         = wr && (off == 4'hA) && data_in[0];
        assign rise        = done[i] & ~done_q;
        // A done edge and a W1C in the same cycle leave the flag set.
        assign sticky_next = rise | (sticky_q & ~clr);
        assign irq_en_next = ctrl_wr ? data_in[2] : irq_en_q;

        // COMMIT data is only 8 bits wide, so channels 8 and up cannot be committed.
        if (i < 8) begin : g_commit
            assign do_commit = commit_wr && data_in[i];
        end else begin : g_nocommit
            assign do_commit = 1'b0;
        end

        assign per16 = 16'(sh_per);
        assign wid16 = 16'(sh_wid);
        assign cnt16 = 16'(sh_cnt);
        assign cd16  = 16'(cnt_done_q);

        // Shadow bank takes CPU writes; the active bank only moves on commit.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sh_div  <= DIV_W'(9);
                sh_per  <= PER_W'(128);
                sh_wid  <= PER_W'(1);
                sh_cnt  <= CNT_W'(16);
                act_div <= DIV_W'(9);
                act_per <= PER_W'(128);
                act_wid <= PER_W'(1);
                act_cnt <= CNT_W'(16);
            end else begin
                if (wr) begin
                    case (off)
                        4'h0: sh_div <= DIV_W'(data_in);
                        4'h1: sh_per <= PER_W'(merge_byte(per16, 1'b0, data_in));
                        4'h2: sh_per <= PER_W'(merge_byte(per16, 1'b1, data_in));
                        4'h3: sh_wid <= PER_W'(merge_byte(wid16, 1'b0, data_in));
                        4'h4: sh_wid <= PER_W'(merge_byte(wid16, 1'b1, data_in));
                        4'h5: sh_cnt <= CNT_W'(merge_byte(cnt16, 1'b0, data_in));
                        4'h6: sh_cnt <= CNT_W'(merge_byte(cnt16, 1'b1, data_in));
                        default: ;
                    endcase
                end
                if (do_commit) begin
                    act_div <= sh_div;
                    act_per <= sh_per;
                    act_wid <= sh_wid;
                    act_cnt <= sh_cnt;
                end
            end
        end

        // CTRL and status: a CPU write to CTRL overrides the auto-stop of RUN.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                run_q       <= run_on_reset;
                auto_stop_q <= 1'b0;
                irq_en_q    <= 1'b0;
                sticky_q    <= 1'b0;
                done_q      <= 1'b0;
                cnt_done_q  <= '0;
            end else begin
                done_q     <= done[i];
                cnt_done_q <= count_done[i*CNT_W +: CNT_W];
                sticky_q   <= sticky_next;
                if (ctrl_wr) begin
                    run_q       <= data_in[0];
                    auto_stop_q <= data_in[1];
                    irq_en_q    <= data_in[2];
                end else if (auto_stop_q && rise) begin
                    run_q <= 1'b0;
                end
            end
        end

        always_comb begin
            rd = 8'h00;
            case (off)
                4'h0: rd = 8'(sh_div);
                4'h1: rd = per16[7:0];
                4'h2: rd = per16[15:8];
                4'h3: rd = wid16[7:0];
                4'h4: rd = wid16[15:8];
                4'h5: rd = cnt16[7:0];
                4'h6: rd = cnt16[15:8];
                4'h7: rd = {5'b0, irq_en_q, auto_stop_q, run_q};
                4'h8: rd = cd16[7:0];
                4'h9: rd = cd16[15:8];
                4'hA: rd = {6'b0, done_q, sticky_q};
                default: rd = 8'h00;
            endcase
        end

        assign rd_ch[i]                      = rd;
        assign irq_next_vec[i]               = sticky_next & irq_en_next;
        assign irq_stat[i]                   = sticky_q & irq_en_q;
        assign clk_div[i*DIV_W +: DIV_W]     = act_div;
        assign period[i*PER_W +: PER_W]      = act_per;
        assign width[i*PER_W +: PER_W]       = act_wid;
        assign count[i*CNT_W +: CNT_W]       = act_cnt;
        assign run_ppt[i]                    = run_q;
    end

    // irq follows next-state sticky/enable so it rises the cycle after a done edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq <= 1'b0;
        end else begin
            irq <= |irq_next_vec;
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (page == 4'hF) begin
            case (off)
                4'h0: data_out = {4'h2, 4'(NUM_CH)};
                4'h2: data_out = 8'(irq_stat);
                default: data_out = 8'h00;
            endcase
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (page == 4'(i)) begin
                    data_out = rd_ch[i];
                end
            end
        end
    end

endmodule
